// File: rtl/kronos_mem_arbiter.sv
// Instruction/data arbiter in front of one single-port synchronous RAM.
// Define ARB_ROUND_ROBIN_EN for alternating grants; default is data-over-instr priority.
module kronos_mem_arbiter #(
  parameter int          ADDR_W     = 12,
  parameter int          RD_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_addr,
  input  logic              instr_req,
  output logic              instr_ack,
  output logic [31:0]       instr_data,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wr_data,
  input  logic [3:0]        data_mask,
  input  logic              data_wr_en,
  input  logic              data_req,
  output logic              data_ack,
  output logic [31:0]       data_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wr_data,
  output logic [3:0]        mem_byte_en,
  output logic              mem_wr_en,
  input  logic [31:0]       mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_t      state_q, state_d;
  logic        gnt_data_q;
  logic        wr_q;
  logic        rng_q;
  logic [1:0]  cnt_q;
  logic        any_req;
  logic        sel_data;
  logic        req_wr;
  logic        go_resp;
  logic        in_range;
  logic [31:0] req_addr;
  logic [31:0] off;
  logic [31:0] word;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant_q <= 1'b0;
    else if (state_q == IDLE && any_req)
      last_grant_q <= sel_data;
  end
`endif

  always_comb begin
    any_req  = instr_req | data_req;
`ifdef ARB_ROUND_ROBIN_EN
    sel_data = data_req & (~instr_req | ~last_grant_q);
`else
    sel_data = data_req;
`endif
    req_addr = sel_data ? data_addr : instr_addr;
    req_wr   = sel_data & data_wr_en;
    off      = req_addr - BASE_ADDR;
    word     = off >> 2;
    in_range = (word >> ADDR_W) == 32'h0;
    // Read data is valid LAT cycles into ACCESS.
    go_resp  = wr_q | (cnt_q == LAT);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (go_resp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_data_q   <= 1'b0;
      wr_q         <= 1'b0;
      rng_q        <= 1'b0;
      cnt_q        <= 2'd0;
      instr_ack    <= 1'b0;
      instr_data   <= 32'h0;
      data_ack     <= 1'b0;
      data_rd_data <= 32'h0;
      mem_addr     <= '0;
      mem_wr_data  <= 32'h0;
      mem_byte_en  <= 4'h0;
      mem_wr_en    <= 1'b0;
    end else begin
      instr_ack <= 1'b0;
      data_ack  <= 1'b0;
      mem_wr_en <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_data_q  <= sel_data;
            wr_q        <= req_wr;
            rng_q       <= in_range;
            cnt_q       <= 2'd0;
            mem_addr    <= word[ADDR_W-1:0];
            mem_wr_data <= sel_data ? data_wr_data : 32'h0;
            mem_byte_en <= req_wr ? data_mask : 4'hF;
            mem_wr_en   <= req_wr & in_range;
          end
        end
        ACCESS: begin
          if (go_resp) begin
            instr_ack <= ~gnt_data_q;
            data_ack  <= gnt_data_q;
            if (!wr_q) begin
              if (gnt_data_q)
                data_rd_data <= rng_q ? mem_rd_data : 32'h0;
              else
                instr_data <= rng_q ? mem_rd_data : 32'h0;
            end
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
